// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller for the HI/LO multiply/divide unit.
// Decodes md-class ops, stalls D while the unit is busy, and registers mfhi/mflo into M.
module md_issue_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        E_VALID,
  input  logic [2:0]  E_FUNC,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_MD,
  input  logic        MD_BUSY,
  input  logic [31:0] MD_HI,
  input  logic [31:0] MD_LO,
  output logic        MD_START,
  output logic [1:0]  MD_OP,
  output logic        MD_WE_HI,
  output logic        MD_WE_LO,
  output logic [31:0] MD_D1,
  output logic [31:0] MD_D2,
  output logic        STALL,
  output logic [31:0] MF_RESULT_M,
  output logic        MF_VALID_M,
  output logic [31:0] STALL_CNT,
  output logic        ERR
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [4:0] RC_LAST = 5'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [4:0]  rc_q, rc_d;
  logic [31:0] mf_result_q, mf_result_d;
  logic        mf_valid_q, mf_valid_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        err_q, err_d;
  logic        issue, mf_sel;

  assign MD_OP       = E_FUNC[1:0];
  assign MD_D1       = E_RS;
  assign MD_D2       = E_RT;
  assign MF_RESULT_M = mf_result_q;
  assign MF_VALID_M  = mf_valid_q;
  assign STALL_CNT   = stall_cnt_q;
  assign ERR         = err_q;

  always_comb begin
    issue    = E_VALID & (state_q == S_IDLE);
    MD_START = issue & ~E_FUNC[2];
    MD_WE_HI = issue & (E_FUNC == 3'd4);
    MD_WE_LO = issue & (E_FUNC == 3'd5);
    mf_sel   = issue & (E_FUNC[2:1] == 2'b11);
    STALL    = D_MD & (MD_START | (state_q == S_RUN));

    state_d     = state_q;
    rc_d        = rc_q;
    err_d       = err_q;
    mf_valid_d  = mf_sel;
    mf_result_d = mf_sel ? (E_FUNC[0] ? MD_LO : MD_HI) : mf_result_q;
    stall_cnt_d = (STALL && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (MD_START) begin
          state_d = S_RUN;
          rc_d    = 5'd0;
        end
      end
      S_RUN: begin
        rc_d = rc_q + 5'd1;
        // An E-stage md op while RUN slipped past the stall: flag it, keep waiting on the unit.
        if (E_VALID) err_d = 1'b1;
        if (!MD_BUSY) begin
          state_d = S_IDLE;
          if (rc_q == 5'd0) err_d = 1'b1;
        end else if (rc_q == RC_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rc_q        <= 5'd0;
      mf_result_q <= 32'd0;
      mf_valid_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      mf_result_q <= mf_result_d;
      mf_valid_q  <= mf_valid_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: decode table, multi-cycle op sequences, error paths,
// with a behavioural HI/LO unit and a scoreboard for mfhi/mflo results.
module tb_md_issue_ctrl;

  logic        CLK, RESET, E_VALID, D_MD, MD_BUSY;
  logic [2:0]  E_FUNC;
  logic [31:0] E_RS, E_RT, MD_HI, MD_LO;
  logic        MD_START, MD_WE_HI, MD_WE_LO, STALL, MF_VALID_M, ERR;
  logic [1:0]  MD_OP;
  logic [31:0] MD_D1, MD_D2, MF_RESULT_M, STALL_CNT;

  md_issue_ctrl #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .E_VALID(E_VALID), .E_FUNC(E_FUNC), .E_RS(E_RS), .E_RT(E_RT),
    .D_MD(D_MD), .MD_BUSY(MD_BUSY), .MD_HI(MD_HI), .MD_LO(MD_LO),
    .MD_START(MD_START), .MD_OP(MD_OP), .MD_WE_HI(MD_WE_HI), .MD_WE_LO(MD_WE_LO),
    .MD_D1(MD_D1), .MD_D2(MD_D2), .STALL(STALL), .MF_RESULT_M(MF_RESULT_M),
    .MF_VALID_M(MF_VALID_M), .STALL_CNT(STALL_CNT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unit model: BUSY drops in the last RUN cycle so the controller releases at its end
  // (mult: 5 RUN cycles, div: 10), results land in HI/LO before the release.
  logic [3:0]  bcnt;
  logic [31:0] hi_r, lo_r, p_hi, p_lo, d2nz, uq, ur;
  logic signed [31:0] sq, sr;
  logic [63:0] mul;
  logic        hold_busy, kill_busy;

  assign d2nz = (MD_D2 == 32'd0) ? 32'd1 : MD_D2;
  assign uq   = MD_D1 / d2nz;
  assign ur   = MD_D1 % d2nz;
  assign sq   = $signed(MD_D1) / $signed(d2nz);
  assign sr   = $signed(MD_D1) % $signed(d2nz);
  assign mul  = MD_OP[0] ? ({{32{MD_D1[31]}}, MD_D1} * {{32{MD_D2[31]}}, MD_D2})
                         : ({32'd0, MD_D1} * {32'd0, MD_D2});
  assign MD_BUSY = ~kill_busy & ((bcnt != 4'd0) | hold_busy);
  assign MD_HI   = hi_r;
  assign MD_LO   = lo_r;

  always @(posedge CLK) begin
    if (RESET) begin
      bcnt <= 4'd0; hi_r <= 32'd0; lo_r <= 32'd0; p_hi <= 32'd0; p_lo <= 32'd0;
    end else begin
      if (MD_START) begin
        bcnt <= MD_OP[1] ? 4'd9 : 4'd4;
        p_hi <= MD_OP[1] ? (MD_OP[0] ? sr : ur) : mul[63:32];
        p_lo <= MD_OP[1] ? (MD_OP[0] ? sq : uq) : mul[31:0];
      end else if (bcnt != 4'd0) begin
        bcnt <= bcnt - 4'd1;
        if (bcnt == 4'd1) begin hi_r <= p_hi; lo_r <= p_lo; end
      end
      if (MD_WE_HI) hi_r <= MD_D1;
      if (MD_WE_LO) lo_r <= MD_D1;
    end
  end

  int n_chk, n_pass;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    #2;
    if (MF_VALID_M === 1'b1) begin
      if (sb.size() == 0) chk("mf_unexpected", 32'(MF_VALID_M), 32'd0);
      else chk("mf_result", MF_RESULT_M, sb.pop_front());
    end
  end

  task automatic drv(input logic ev, input logic [2:0] f, input logic [31:0] rs, input logic [31:0] rt,
                     input logic dmd);
    @(negedge CLK);
    E_VALID = ev; E_FUNC = f; E_RS = rs; E_RT = rt; D_MD = dmd;
    #1;
  endtask

  task automatic idle(input logic dmd);
    drv(1'b0, 3'd0, 32'd0, 32'd0, dmd);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET = 1'b1; E_VALID = 1'b0; D_MD = 1'b0; hold_busy = 1'b0; kill_busy = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    idle(1'b1);
    while (STALL === 1'b1 && n < 40) begin idle(1'b1); n++; end
    if (n >= 40) chk("idle_timeout", 32'(STALL), 32'd0);
  endtask

  typedef struct {
    logic        ev;
    logic [2:0]  func;
    logic        dmd;
    logic [31:0] rs;
    logic        e_start, e_whi, e_wlo, e_stall;
  } vec_t;
  vec_t vt[10];

  initial begin
    RESET = 1'b1; E_VALID = 1'b0; E_FUNC = 3'd0; E_RS = 32'd0; E_RT = 32'd0; D_MD = 1'b0;
    hold_busy = 1'b0; kill_busy = 1'b0; n_chk = 0; n_pass = 0;

    vt[0] = '{1'b0, 3'd0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 3'd0, 1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 3'd1, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 3'd2, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 3'd3, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 3'd4, 1'b1, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 3'd5, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b1, 3'd6, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b1, 3'd7, 1'b0, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 3'd4, 1'b1, 32'haa, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset;
    idle(1'b1);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_start", 32'(MD_START), 32'd0);
    chk("rst_we_hi", 32'(MD_WE_HI), 32'd0);
    chk("rst_we_lo", 32'(MD_WE_LO), 32'd0);
    chk("rst_mf_valid", 32'(MF_VALID_M), 32'd0);
    chk("rst_mf_result", MF_RESULT_M, 32'd0);
    chk("rst_stall_cnt", STALL_CNT, 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);

    // Decode table, each row from a freshly reset IDLE controller (HI/LO are 0)
    for (int i = 0; i < 10; i++) begin
      drv(vt[i].ev, vt[i].func, vt[i].rs, 32'h5, vt[i].dmd);
      chk($sformatf("tbl%0d_start", i), 32'(MD_START), 32'(vt[i].e_start));
      chk($sformatf("tbl%0d_we_hi", i), 32'(MD_WE_HI), 32'(vt[i].e_whi));
      chk($sformatf("tbl%0d_we_lo", i), 32'(MD_WE_LO), 32'(vt[i].e_wlo));
      chk($sformatf("tbl%0d_stall", i), 32'(STALL), 32'(vt[i].e_stall));
      chk($sformatf("tbl%0d_op", i), 32'(MD_OP), 32'(vt[i].func[1:0]));
      chk($sformatf("tbl%0d_d1", i), MD_D1, vt[i].rs);
      if (vt[i].ev && vt[i].func[2:1] == 2'b11) sb.push_back(32'd0);
      @(negedge CLK); RESET = 1'b1; E_VALID = 1'b0;
      @(negedge CLK); RESET = 1'b0;
    end

    // mult -1 * 2 with a stalled mfhi/mflo behind it
    do_reset;
    drv(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("mul_start_t", 32'(MD_START), 32'd1);
    chk("mul_stall_t", 32'(STALL), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      idle(1'b1);
      chk($sformatf("mul_stall_t%0d", i), 32'(STALL), 32'd1);
      chk($sformatf("mul_start_t%0d", i), 32'(MD_START), 32'd0);
    end
    idle(1'b1);
    chk("mul_stall_t6", 32'(STALL), 32'd0);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b1);
    sb.push_back(32'hFFFF_FFFF);
    chk("mul_mfhi_stall", 32'(STALL), 32'd0);
    drv(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'hFFFF_FFFE);
    idle(1'b0);
    chk("mul_stall_cnt", STALL_CNT, 32'd6);

    // divu 7/2 with mflo then mfhi queued
    drv(1'b1, 3'd2, 32'd7, 32'd2, 1'b1);
    chk("div_stall_t", 32'(STALL), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      chk($sformatf("div_stall_t%0d", i), 32'(STALL), 32'd1);
    end
    idle(1'b1);
    chk("div_stall_t11", 32'(STALL), 32'd0);
    drv(1'b1, 3'd7, 32'd0, 32'd0, 1'b1);
    sb.push_back(32'd3);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'd1);
    idle(1'b0);
    chk("div_stall_cnt", STALL_CNT, 32'd17);

    // mthi/mtlo followed immediately by mfhi/mflo
    drv(1'b1, 3'd4, 32'h1234, 32'd0, 1'b1);
    chk("mthi_we", 32'(MD_WE_HI), 32'd1);
    chk("mthi_start", 32'(MD_START), 32'd0);
    chk("mthi_stall", 32'(STALL), 32'd0);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'h1234);
    drv(1'b1, 3'd5, 32'hABCD, 32'd0, 1'b0);
    chk("mtlo_we", 32'(MD_WE_LO), 32'd1);
    drv(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'hABCD);
    idle(1'b0);

    // Hazard escape: mthi and mfhi during RUN are suppressed and flag ERR
    do_reset;
    drv(1'b1, 3'd0, 32'd3, 32'd5, 1'b1);
    idle(1'b1);
    drv(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b1);
    chk("esc_we_hi", 32'(MD_WE_HI), 32'd0);
    chk("esc_start", 32'(MD_START), 32'd0);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b1);
    chk("esc_err", 32'(ERR), 32'd1);
    wait_idle;
    chk("esc_err_sticky", 32'(ERR), 32'd1);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'd0);
    idle(1'b0);
    chk("esc_err_sticky2", 32'(ERR), 32'd1);
    do_reset;
    idle(1'b0);
    chk("esc_err_cleared", 32'(ERR), 32'd0);

    // BUSY never rises: error exit from the first RUN cycle
    do_reset;
    kill_busy = 1'b1;
    drv(1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    chk("early_start", 32'(MD_START), 32'd1);
    idle(1'b1);
    chk("early_run_stall", 32'(STALL), 32'd1);
    chk("early_err0", 32'(ERR), 32'd0);
    idle(1'b1);
    chk("early_idle_stall", 32'(STALL), 32'd0);
    chk("early_err1", 32'(ERR), 32'd1);

    // BUSY stuck high: timeout after 16 RUN cycles
    do_reset;
    hold_busy = 1'b1;
    drv(1'b1, 3'd1, 32'd1, 32'd1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      idle(1'b1);
      chk($sformatf("to_stall_t%0d", i), 32'(STALL), 32'd1);
      chk($sformatf("to_err_t%0d", i), 32'(ERR), 32'd0);
    end
    idle(1'b1);
    chk("to_stall_exit", 32'(STALL), 32'd0);
    chk("to_err_exit", 32'(ERR), 32'd1);
    hold_busy = 1'b0;

    // RESET at t+2 of a div discards it and clears ERR/counters
    do_reset;
    drv(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
    drv(1'b1, 3'd4, 32'd1, 32'd0, 1'b1);
    idle(1'b1);
    chk("rdiv_err_before", 32'(ERR), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rdiv_stall", 32'(STALL), 32'd0);
    chk("rdiv_err", 32'(ERR), 32'd0);
    chk("rdiv_mf_valid", 32'(MF_VALID_M), 32'd0);
    chk("rdiv_stall_cnt", STALL_CNT, 32'd0);
    drv(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
    chk("rdiv_reissue", 32'(MD_START), 32'd1);
    wait_idle;
    drv(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
    sb.push_back(32'd6);
    idle(1'b0);
    idle(1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
